// File: rtl/vpx_link_tester.sv
// VPX backplane link tester: per-channel counter/PRBS7 generators, self-synchronising PRBS7
// checkers and trigger edge counters. Define VPX_ERR_INJ_EN to add the ERR_INJ bit-error input.
module vpx_link_tester #(
    parameter int NUM_CH     = 8,
    parameter int NUM_TRIG   = 2,
    parameter int ERR_CNT_W  = 16,
    parameter int TRIG_CNT_W = 16,
    parameter int LOCK_CNT   = 16
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic                           START,
    input  logic                           STOP,
    input  logic                           CLR,
    input  logic                           MODE,
    input  logic [NUM_CH-1:0]              CH_DIR,
    output logic [NUM_CH-1:0]              PAD_O,
    output logic [NUM_CH-1:0]              PAD_OE,
    input  logic [NUM_CH-1:0]              PAD_I,
    input  logic [NUM_TRIG-1:0]            TRIG_I,
`ifdef VPX_ERR_INJ_EN
    input  logic [NUM_CH-1:0]              ERR_INJ,
`endif
    output logic                           BUSY,
    output logic [NUM_CH-1:0]              LOCKED,
    output logic [NUM_CH*ERR_CNT_W-1:0]    ERR_CNT,
    output logic [NUM_TRIG*TRIG_CNT_W-1:0] TRIG_CNT
);

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic {CHK_HUNT, CHK_LOCKED} chk_t;

    localparam logic [NUM_CH-1:0]     CNT_ONE   = 1;
    localparam logic [ERR_CNT_W-1:0]  ERR_ONE   = 1;
    localparam logic [TRIG_CNT_W-1:0] TRIG_ONE  = 1;
    localparam logic [7:0]            LOCK_LAST = 8'(LOCK_CNT - 1);

    state_t                state, state_next;
    logic [NUM_CH-1:0]     count, pattern, inj, pad_q, mis, active;
    logic [6:0]            lfsr [NUM_CH];
    logic [6:0]            shreg [NUM_CH];
    logic [6:0]            shreg_next [NUM_CH];
    logic [7:0]            run_cnt [NUM_CH];
    logic [7:0]            run_cnt_next [NUM_CH];
    chk_t                  chk [NUM_CH];
    chk_t                  chk_next [NUM_CH];
    logic [ERR_CNT_W-1:0]  err [NUM_CH];
    logic [ERR_CNT_W-1:0]  err_next [NUM_CH];
    logic [NUM_TRIG-1:0]   trig_s1, trig_s2, trig_s3;
    logic [TRIG_CNT_W-1:0] trig_cnt [NUM_TRIG];

    function automatic logic [6:0] seed(input int k);
        return 7'((k % 127) + 1);
    endfunction

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            BUSY  <= 1'b0;
        end else begin
            state <= state_next;
            BUSY  <= (state_next == RUN);
        end
    end

    // STOP has priority; START in RUN simply keeps RUN
    always_comb begin
        state_next = state;
        if (STOP)
            state_next = IDLE;
        else if (START)
            state_next = RUN;
    end

    always_comb begin
        pattern = '0;
        inj     = '0;
        for (int k = 0; k < NUM_CH; k++)
            pattern[k] = MODE ? lfsr[k][6] : count[k];
`ifdef VPX_ERR_INJ_EN
        inj = ERR_INJ & ~CH_DIR;
`endif
    end

    // Outside RUN the generators sit at their start values, so entering RUN always begins fresh
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count  <= '0;
            PAD_O  <= '0;
            PAD_OE <= '0;
            for (int k = 0; k < NUM_CH; k++)
                lfsr[k] <= seed(k);
        end else if (BUSY) begin
            count  <= count + CNT_ONE;
            PAD_O  <= pattern ^ inj;
            PAD_OE <= ~CH_DIR;
            for (int k = 0; k < NUM_CH; k++)
                lfsr[k] <= {lfsr[k][5:0], lfsr[k][6] ^ lfsr[k][5]};
        end else begin
            count  <= '0;
            PAD_O  <= '0;
            PAD_OE <= '0;
            for (int k = 0; k < NUM_CH; k++)
                lfsr[k] <= seed(k);
        end
    end

    // run_cnt counts consecutive matches in HUNT and consecutive mismatches in LOCKED
    always_comb begin
        active = '0;
        mis    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            active[k]       = BUSY & CH_DIR[k] & MODE;
            mis[k]          = pad_q[k] ^ shreg[k][6] ^ shreg[k][5];
            shreg_next[k]   = '0;
            run_cnt_next[k] = '0;
            chk_next[k]     = CHK_HUNT;
            err_next[k]     = err[k];
            if (active[k]) begin
                shreg_next[k] = {shreg[k][5:0], pad_q[k]};
                if (chk[k] == CHK_HUNT) begin
                    if (!mis[k]) begin
                        if (run_cnt[k] == LOCK_LAST)
                            chk_next[k] = CHK_LOCKED;
                        else
                            run_cnt_next[k] = run_cnt[k] + 8'd1;
                    end
                end else begin
                    chk_next[k] = CHK_LOCKED;
                    if (mis[k]) begin
                        if (err[k] != '1)
                            err_next[k] = err[k] + ERR_ONE;
                        if (run_cnt[k] == 8'd3)
                            chk_next[k] = CHK_HUNT;
                        else
                            run_cnt_next[k] = run_cnt[k] + 8'd1;
                    end
                end
            end
            if (CLR)
                err_next[k] = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pad_q <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                shreg[k]   <= '0;
                run_cnt[k] <= '0;
                chk[k]     <= CHK_HUNT;
                err[k]     <= '0;
            end
        end else begin
            pad_q <= PAD_I;
            for (int k = 0; k < NUM_CH; k++) begin
                shreg[k]   <= shreg_next[k];
                run_cnt[k] <= run_cnt_next[k];
                chk[k]     <= chk_next[k];
                err[k]     <= err_next[k];
            end
        end
    end

    // trig_s3 only serves as the previous synchronised value for edge detection
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            trig_s1 <= '0;
            trig_s2 <= '0;
            trig_s3 <= '0;
            for (int j = 0; j < NUM_TRIG; j++)
                trig_cnt[j] <= '0;
        end else begin
            trig_s1 <= TRIG_I;
            trig_s2 <= trig_s1;
            trig_s3 <= trig_s2;
            for (int j = 0; j < NUM_TRIG; j++) begin
                if (CLR)
                    trig_cnt[j] <= '0;
                else if (BUSY && trig_s2[j] && !trig_s3[j] && trig_cnt[j] != '1)
                    trig_cnt[j] <= trig_cnt[j] + TRIG_ONE;
            end
        end
    end

    always_comb begin
        LOCKED   = '0;
        ERR_CNT  = '0;
        TRIG_CNT = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            LOCKED[k]                         = (chk[k] == CHK_LOCKED);
            ERR_CNT[k*ERR_CNT_W +: ERR_CNT_W] = err[k];
        end
        for (int j = 0; j < NUM_TRIG; j++)
            TRIG_CNT[j*TRIG_CNT_W +: TRIG_CNT_W] = trig_cnt[j];
    end

endmodule

// File: tb/tb_vpx_link_tester.sv
// Self-checking bench for vpx_link_tester: directed phases plus randomized traffic compared
// every cycle against a stream-level reference model. Honours VPX_ERR_INJ_EN when defined.
module tb_vpx_link_tester;

    localparam int NCH   = 8;
    localparam int NTRIG = 2;
    localparam int EW    = 4;
    localparam int TW    = 4;
    localparam int LOCKN = 16;
    localparam int EMAX  = (1 << EW) - 1;
    localparam int TMAX  = (1 << TW) - 1;
`ifdef VPX_ERR_INJ_EN
    localparam bit INJ_EN = 1'b1;
`else
    localparam bit INJ_EN = 1'b0;
`endif

    logic                CLK = 1'b0;
    logic                RST_N, START, STOP, CLR, MODE, BUSY;
    logic [NCH-1:0]      CH_DIR, PAD_O, PAD_OE, PAD_I, LOCKED, err_inj;
    logic [NTRIG-1:0]    TRIG_I;
    logic [NCH*EW-1:0]   ERR_CNT;
    logic [NTRIG*TW-1:0] TRIG_CNT;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit             prbs [NCH][127];
    bit             rx_hist [NCH][8192];
    int             rx_len [NCH];
    int             match_run [NCH];
    int             miss_run [NCH];
    bit             lock_m [NCH];
    int             exp_err [NCH];
    int             exp_trig [NTRIG];
    bit             m_busy;
    int             run_idx;
    logic [NCH-1:0] exp_pad_o, exp_pad_oe, exp_locked, last_pad_i;
    logic [NTRIG-1:0] trig_d1, trig_d2, trig_d3;

    always #5 CLK = ~CLK;

    vpx_link_tester #(
        .NUM_CH(NCH), .NUM_TRIG(NTRIG), .ERR_CNT_W(EW), .TRIG_CNT_W(TW), .LOCK_CNT(LOCKN)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP), .CLR(CLR), .MODE(MODE),
        .CH_DIR(CH_DIR), .PAD_O(PAD_O), .PAD_OE(PAD_OE), .PAD_I(PAD_I), .TRIG_I(TRIG_I),
`ifdef VPX_ERR_INJ_EN
        .ERR_INJ(err_inj),
`endif
        .BUSY(BUSY), .LOCKED(LOCKED), .ERR_CNT(ERR_CNT), .TRIG_CNT(TRIG_CNT)
    );

    // PRBS7 bit stream of x^7+x^6+1 obeys s[n] = s[n-7] ^ s[n-6]; first 7 bits are the seed MSB-first
    function automatic void build_prbs();
        logic [6:0] s;
        for (int k = 0; k < NCH; k++) begin
            s = 7'((k % 127) + 1);
            for (int i = 0; i < 7; i++)
                prbs[k][i] = s[6-i];
            for (int i = 7; i < 127; i++)
                prbs[k][i] = prbs[k][i-7] ^ prbs[k][i-6];
        end
    endfunction

    function automatic void model_reset();
        m_busy     = 1'b0;
        run_idx    = 0;
        exp_pad_o  = '0;
        exp_pad_oe = '0;
        exp_locked = '0;
        last_pad_i = '0;
        trig_d1    = '0;
        trig_d2    = '0;
        trig_d3    = '0;
        for (int k = 0; k < NCH; k++) begin
            rx_len[k] = 0; match_run[k] = 0; miss_run[k] = 0; lock_m[k] = 1'b0; exp_err[k] = 0;
        end
        for (int j = 0; j < NTRIG; j++)
            exp_trig[j] = 0;
    endfunction

    // advance the model by one clock edge using the inputs presented before that edge
    task automatic model_edge();
        bit busy_prev, pat, d, a, b, mis, rose;
        busy_prev = m_busy;
        for (int k = 0; k < NCH; k++) begin
            if (busy_prev) begin
                pat           = MODE ? prbs[k][run_idx % 127] : bit'((run_idx >> k) & 1);
                exp_pad_o[k]  = pat ^ (INJ_EN & err_inj[k] & ~CH_DIR[k]);
                exp_pad_oe[k] = ~CH_DIR[k];
            end else begin
                exp_pad_o[k]  = 1'b0;
                exp_pad_oe[k] = 1'b0;
            end
            if (busy_prev && CH_DIR[k] && MODE) begin
                d = last_pad_i[k];
                a = (rx_len[k] >= 7) ? rx_hist[k][rx_len[k]-7] : 1'b0;
                b = (rx_len[k] >= 6) ? rx_hist[k][rx_len[k]-6] : 1'b0;
                mis = (d != (a ^ b));
                if (rx_len[k] < 8192) begin
                    rx_hist[k][rx_len[k]] = d;
                    rx_len[k]++;
                end
                if (!lock_m[k]) begin
                    if (mis) match_run[k] = 0;
                    else begin
                        match_run[k]++;
                        if (match_run[k] == LOCKN) begin lock_m[k] = 1'b1; miss_run[k] = 0; end
                    end
                end else if (mis) begin
                    if (exp_err[k] < EMAX) exp_err[k]++;
                    miss_run[k]++;
                    if (miss_run[k] == 4) begin lock_m[k] = 1'b0; match_run[k] = 0; end
                end else
                    miss_run[k] = 0;
            end else begin
                rx_len[k] = 0; match_run[k] = 0; miss_run[k] = 0; lock_m[k] = 1'b0;
            end
            if (CLR) exp_err[k] = 0;
            exp_locked[k] = lock_m[k];
        end
        for (int j = 0; j < NTRIG; j++) begin
            rose = trig_d2[j] & ~trig_d3[j];
            if (CLR) exp_trig[j] = 0;
            else if (busy_prev && rose && exp_trig[j] < TMAX) exp_trig[j]++;
        end
        trig_d3 = trig_d2; trig_d2 = trig_d1; trig_d1 = TRIG_I;
        last_pad_i = PAD_I;
        if (busy_prev) run_idx++; else run_idx = 0;
        if (STOP) m_busy = 1'b0;
        else if (START) m_busy = 1'b1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        check_val("busy", 32'(BUSY), 32'(m_busy));
        check_val("pad_o", 32'(PAD_O), 32'(exp_pad_o));
        check_val("pad_oe", 32'(PAD_OE), 32'(exp_pad_oe));
        check_val("locked", 32'(LOCKED), 32'(exp_locked));
        for (int k = 0; k < NCH; k++)
            check_val($sformatf("err_cnt[%0d]", k), 32'(ERR_CNT[k*EW +: EW]), 32'(exp_err[k]));
        for (int j = 0; j < NTRIG; j++)
            check_val($sformatf("trig_cnt[%0d]", j), 32'(TRIG_CNT[j*TW +: TW]), 32'(exp_trig[j]));
    endtask

    task automatic apply_stimulus();
        @(posedge CLK);
        model_edge();
        #1;
        check_output();
    endtask

    // loop the channel-0 stream back onto PAD_I[1]; other inputs get random bits
    task automatic drive_loop(input bit flip, input bit force_one);
        PAD_I    = NCH'($urandom);
        PAD_I[1] = force_one ? 1'b1 : (exp_pad_o[0] ^ flip);
    endtask

    task automatic restart_run(input logic [NCH-1:0] dir, input logic mode);
        STOP = 1'b1; apply_stimulus(); STOP = 1'b0;
        CH_DIR = dir; MODE = mode;
        START = 1'b1; apply_stimulus(); START = 1'b0;
    endtask

    task automatic trig_pulse(input int j);
        TRIG_I[j] = 1'b1; repeat (3) apply_stimulus();
        TRIG_I[j] = 1'b0; repeat (3) apply_stimulus();
    endtask

    initial begin
        RST_N = 1'b0; START = 1'b0; STOP = 1'b0; CLR = 1'b0; MODE = 1'b0;
        CH_DIR = '0; PAD_I = '0; TRIG_I = '0; err_inj = '0;
        build_prbs();
        model_reset();
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        check_output();

        // all channels driving PRBS7, long enough to wrap the 127-bit period twice
        $display("[TB] phase: PRBS generation");
        restart_run('1, 1'b1);
        repeat (260) apply_stimulus();
        STOP = 1'b1; apply_stimulus(); STOP = 1'b0;
        repeat (3) apply_stimulus();

        $display("[TB] phase: loopback lock");
        restart_run(8'h02, 1'b1);
        repeat (400) begin drive_loop(1'b0, 1'b0); apply_stimulus(); end
        check_val("lock_after_loopback", 32'(LOCKED[1]), 32'd1);
        check_val("err_clean_loopback", 32'(ERR_CNT[1*EW +: EW]), 32'd0);

        // ten isolated bit flips give three mismatches each and saturate the 4-bit counter
        $display("[TB] phase: error saturation");
        repeat (10) begin
            drive_loop(1'b1, 1'b0); apply_stimulus();
            repeat (19) begin drive_loop(1'b0, 1'b0); apply_stimulus(); end
        end
        check_val("err_saturated", 32'(ERR_CNT[1*EW +: EW]), 32'(EMAX));
        check_val("lock_kept_flips", 32'(LOCKED[1]), 32'd1);
        repeat (20) begin drive_loop(1'b0, 1'b1); apply_stimulus(); end
        check_val("lock_lost_const", 32'(LOCKED[1]), 32'd0);

        $display("[TB] phase: randomized traffic");
        CLR = 1'b1; apply_stimulus(); CLR = 1'b0;
        for (int n = 0; n < 700; n++) begin
            drive_loop($urandom_range(0, 29) == 0, 1'b0);
            if ($urandom_range(0, 99) == 0) CH_DIR = (NCH'($urandom) | 8'h02) & 8'hFE;
            if ($urandom_range(0, 149) == 0) CH_DIR[1] = ~CH_DIR[1];
            if ($urandom_range(0, 99) == 0) MODE = ~MODE;
            START = ($urandom_range(0, 149) == 0);
            STOP  = ($urandom_range(0, 249) == 0);
            CLR   = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 5) == 0) TRIG_I = TRIG_I ^ NTRIG'($urandom_range(1, 3));
            err_inj = ($urandom_range(0, 49) == 0) ? NCH'($urandom) : '0;
            apply_stimulus();
        end
        START = 1'b0; STOP = 1'b0; CLR = 1'b0; err_inj = '0; TRIG_I = '0;

`ifdef VPX_ERR_INJ_EN
        $display("[TB] phase: error injection");
        restart_run(8'h02, 1'b1);
        CLR = 1'b1; drive_loop(1'b0, 1'b0); apply_stimulus(); CLR = 1'b0;
        repeat (100) begin drive_loop(1'b0, 1'b0); apply_stimulus(); end
        repeat (5) begin
            err_inj = 8'h01; drive_loop(1'b0, 1'b0); apply_stimulus(); err_inj = '0;
            repeat (99) begin drive_loop(1'b0, 1'b0); apply_stimulus(); end
        end
        check_val("inj_err_cnt", 32'(ERR_CNT[1*EW +: EW]), 32'd15);
        check_val("inj_lock_kept", 32'(LOCKED[1]), 32'd1);
`endif

        $display("[TB] phase: counter pattern");
        PAD_I = '0;
        restart_run(8'h00, 1'b0);
        repeat (300) apply_stimulus();
        check_val("locked_counter_mode", 32'(LOCKED), 32'd0);

        $display("[TB] phase: triggers");
        STOP = 1'b1; apply_stimulus(); STOP = 1'b0;
        CLR = 1'b1; apply_stimulus(); CLR = 1'b0;
        START = 1'b1; apply_stimulus(); START = 1'b0;
        repeat (5) trig_pulse(1);
        repeat (4) apply_stimulus();
        STOP = 1'b1; apply_stimulus(); STOP = 1'b0;
        repeat (3) trig_pulse(1);
        repeat (4) apply_stimulus();
        check_val("trig_run_only", 32'(TRIG_CNT[1*TW +: TW]), 32'd5);
        START = 1'b1; apply_stimulus(); START = 1'b0;
        TRIG_I[1] = 1'b1; apply_stimulus();
        apply_stimulus();
        CLR = 1'b1; apply_stimulus(); CLR = 1'b0;
        check_val("trig_clr_wins", 32'(TRIG_CNT[1*TW +: TW]), 32'd0);
        repeat (3) apply_stimulus();
        TRIG_I = '0;

        $display("[TB] phase: async reset in RUN");
        CH_DIR = 8'h00;
        repeat (3) apply_stimulus();
        check_val("pad_oe_before_reset", 32'(PAD_OE), 32'hFF);
        RST_N = 1'b0;
        #1;
        check_val("async_rst_pad_oe", 32'(PAD_OE), 32'd0);
        check_val("async_rst_busy", 32'(BUSY), 32'd0);
        check_val("async_rst_pad_o", 32'(PAD_O), 32'd0);
        model_reset();
        @(posedge CLK);
        #1 RST_N = 1'b1;
        repeat (3) apply_stimulus();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
